// File: rtl/decimator_mc.sv
// Multi-channel AXI-Stream decimator: per-channel phase counters, one output per 2^cfg_log2_ratio beats.
// Define DECIMATOR_MC_AVG_EN for boxcar averaging; otherwise the last sample of each group is kept.
module decimator_mc #(
    parameter int DATA_W         = 24,
    parameter int NUM_CH         = 8,
    parameter int MAX_LOG2_RATIO = 4,
    parameter int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int LR_W           = (MAX_LOG2_RATIO > 0) ? $clog2(MAX_LOG2_RATIO + 1) : 1
) (
    input  logic              s_axis_aclk,
    input  logic              s_axis_aresetn,
    input  logic [LR_W-1:0]   cfg_log2_ratio,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [CH_W-1:0]   s_axis_tuser,
    input  logic              s_axis_tlast,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [CH_W-1:0]   m_axis_tuser,
    output logic              m_axis_tlast
);
    localparam int CNT_W = (MAX_LOG2_RATIO > 0) ? MAX_LOG2_RATIO : 1;
    localparam int ACC_W = DATA_W + MAX_LOG2_RATIO;

    logic [DATA_W-1:0] r_tdata;
    logic              r_tvalid;
    logic [CH_W-1:0]   r_tuser;
    logic              r_tlast;

    logic [LR_W-1:0]   w_lr;
    logic [CNT_W-1:0]  w_rm1;
    logic              w_ch_ok;
    logic              w_accept;
    logic              w_emit;
    logic [CNT_W-1:0]  w_cnt_sel;
    logic              w_tl_sel;
    logic [DATA_W-1:0] w_out;
    logic [NUM_CH-1:0] w_hit;
    logic [NUM_CH-1:0][CNT_W-1:0] w_cnt_all;
    logic [NUM_CH-1:0]            w_tl_all;

    assign s_axis_tready = !r_tvalid || m_axis_tready;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tuser  = r_tuser;
    assign m_axis_tlast  = r_tlast;

    assign w_lr  = (cfg_log2_ratio > LR_W'(MAX_LOG2_RATIO)) ? LR_W'(MAX_LOG2_RATIO) : cfg_log2_ratio;
    // R-1 as a mask of w_lr low ones
    assign w_rm1 = ~({CNT_W{1'b1}} << w_lr);

    generate
        if (NUM_CH >= (1 << CH_W)) begin : g_ch_full
            assign w_ch_ok = 1'b1;
        end else begin : g_ch_part
            assign w_ch_ok = (s_axis_tuser < CH_W'(NUM_CH));
        end
    endgenerate

    assign w_accept = s_axis_tvalid && s_axis_tready && w_ch_ok;
    assign w_emit   = w_accept && (w_cnt_sel >= w_rm1);

`ifdef DECIMATOR_MC_AVG_EN
    logic [NUM_CH-1:0][ACC_W-1:0] w_acc_all;
    logic signed [ACC_W-1:0]      w_acc_sel;
    logic signed [ACC_W-1:0]      w_sum;

    assign w_sum = w_acc_sel + ACC_W'($signed(s_axis_tdata));
    assign w_out = DATA_W'(w_sum >>> w_lr);
`else
    assign w_out = s_axis_tdata;
`endif

    always_comb begin
        w_cnt_sel = '0;
        w_tl_sel  = 1'b0;
`ifdef DECIMATOR_MC_AVG_EN
        w_acc_sel = '0;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            if (s_axis_tuser == CH_W'(i)) begin
                w_cnt_sel = w_cnt_all[i];
                w_tl_sel  = w_tl_all[i];
`ifdef DECIMATOR_MC_AVG_EN
                w_acc_sel = $signed(w_acc_all[i]);
`endif
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;
            logic             r_tl;

            assign w_hit[gi]     = w_accept && (s_axis_tuser == CH_W'(gi));
            assign w_cnt_all[gi] = r_cnt;
            assign w_tl_all[gi]  = r_tl;

            always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
                if (!s_axis_aresetn) begin
                    r_cnt <= '0;
                    r_tl  <= 1'b0;
                end else if (w_hit[gi]) begin
                    if (w_emit) begin
                        r_cnt <= '0;
                        r_tl  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        r_tl  <= r_tl | s_axis_tlast;
                    end
                end
            end

`ifdef DECIMATOR_MC_AVG_EN
            logic signed [ACC_W-1:0] r_acc;
            assign w_acc_all[gi] = r_acc;

            always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
                if (!s_axis_aresetn) begin
                    r_acc <= '0;
                end else if (w_hit[gi]) begin
                    r_acc <= w_emit ? '0 : w_sum;
                end
            end
`endif
        end
    endgenerate

    // Single output register: reload on emit, otherwise drain when consumed.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tuser  <= '0;
            r_tlast  <= 1'b0;
        end else if (w_emit) begin
            r_tdata  <= w_out;
            r_tvalid <= 1'b1;
            r_tuser  <= s_axis_tuser;
            r_tlast  <= w_tl_sel | s_axis_tlast;
        end else if (m_axis_tready) begin
            r_tvalid <= 1'b0;
        end
    end

endmodule
